// File: rtl/rf_pkg.sv
// Shared constants and grant encoding for the register-file write-port arbiter.
package rf_pkg;

  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned HI_ADDR    = 32;
  localparam int unsigned LO_ADDR    = 33;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MDU  = 2'd2,
    GNT_LR   = 2'd3
  } gnt_e;

endpackage

// File: rtl/rf_wb_hold_buf.sv
// One-entry valid/ready holding buffer with a saturating starvation counter.
// Ready stays low for one cycle after a grant, so the slot is never refilled
// in the same cycle it drains.
module rf_wb_hold_buf #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_grant,
  output logic             o_ready,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data,
  output logic             o_starved
);

  logic             r_full;
  logic             r_drained;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_limit;

  assign w_limit   = CNT_W'(STARVE_LIMIT);
  assign o_ready   = ~r_full & ~r_drained;
  assign o_full    = r_full;
  assign o_data    = r_data;
  assign o_starved = (r_cnt == w_limit);

  // Slot occupancy: drain on grant, capture on valid&ready.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_full    <= 1'b0;
      r_drained <= 1'b0;
      r_data    <= '0;
    end else begin
      r_drained <= i_grant;
      if (i_grant) begin
        r_full <= 1'b0;
      end else if (i_valid && o_ready) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end
    end
  end

  // Starvation count: cycles spent full without a grant, saturating.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (!r_full || i_grant) begin
      r_cnt <= '0;
    end else if (r_cnt != w_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: writeback has fixed priority, the MDU
// (HI/LO double write) and load-return buffers are served round-robin, and
// a starvation stall holds writeback so buffered results always drain.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = rf_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = rf_pkg::DATA_WIDTH,
  parameter int unsigned HI_ADDR      = rf_pkg::HI_ADDR,
  parameter int unsigned LO_ADDR      = rf_pkg::LO_ADDR,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_wb_valid,
  input  logic [ADDR_WIDTH-1:0]   i_wb_addr,
  input  logic [DATA_WIDTH-1:0]   i_wb_data,
  output logic                    o_wb_stall,
  input  logic                    i_mdu_valid,
  output logic                    o_mdu_ready,
  input  logic [2*DATA_WIDTH-1:0] i_mdu_hilo,
  input  logic                    i_lr_valid,
  output logic                    o_lr_ready,
  input  logic [ADDR_WIDTH-1:0]   i_lr_addr,
  input  logic [DATA_WIDTH-1:0]   i_lr_data,
  output logic                    o_hilo_pending,
  output logic                    o_lr_pending,
  output logic [ADDR_WIDTH-1:0]   o_lr_pend_addr,
  output logic                    o_rf_wen,
  output logic                    o_rf_double_en,
  output logic [ADDR_WIDTH-1:0]   o_rf_waddr,
  output logic [DATA_WIDTH-1:0]   o_rf_wdata,
  output logic [2*DATA_WIDTH-1:0] o_rf_double_wdata,
  output logic                    o_proto_err
);

  localparam int unsigned LrW = ADDR_WIDTH + DATA_WIDTH;

  // Elaboration guards on parameter consistency.
  if (HI_ADDR >= (1 << ADDR_WIDTH) || LO_ADDR >= (1 << ADDR_WIDTH)) begin : g_bad_hilo
    $error("HI_ADDR/LO_ADDR outside register address range");
  end
  if ((1 << CNT_W) <= STARVE_LIMIT) begin : g_bad_cnt
    $error("CNT_W too narrow for STARVE_LIMIT");
  end

  gnt_e                    w_gnt;
  logic                    w_wb_req;
  logic                    w_gnt_mdu;
  logic                    w_gnt_lr;
  logic                    w_mdu_full;
  logic                    w_lr_full;
  logic                    w_mdu_starved;
  logic                    w_lr_starved;
  logic [2*DATA_WIDTH-1:0] w_mdu_data;
  logic [LrW-1:0]          w_lr_payload;
  logic [ADDR_WIDTH-1:0]   w_lr_addr;
  logic [DATA_WIDTH-1:0]   w_lr_data;

  logic                    r_rr_ptr;  // 0: MDU preferred, 1: LR preferred
  logic                    r_wb_stall;
  logic                    r_proto_err;
  logic                    r_rf_wen;
  logic                    r_rf_double_en;
  logic [ADDR_WIDTH-1:0]   r_rf_waddr;
  logic [DATA_WIDTH-1:0]   r_rf_wdata;
  logic [2*DATA_WIDTH-1:0] r_rf_double_wdata;

  rf_wb_hold_buf #(
    .WIDTH        (2 * DATA_WIDTH),
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_mdu_buf (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   (i_mdu_valid),
    .i_data    (i_mdu_hilo),
    .i_grant   (w_gnt_mdu),
    .o_ready   (o_mdu_ready),
    .o_full    (w_mdu_full),
    .o_data    (w_mdu_data),
    .o_starved (w_mdu_starved)
  );

  rf_wb_hold_buf #(
    .WIDTH        (LrW),
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_lr_buf (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   (i_lr_valid),
    .i_data    ({i_lr_addr, i_lr_data}),
    .i_grant   (w_gnt_lr),
    .o_ready   (o_lr_ready),
    .o_full    (w_lr_full),
    .o_data    (w_lr_payload),
    .o_starved (w_lr_starved)
  );

  assign w_lr_addr = w_lr_payload[LrW-1:DATA_WIDTH];
  assign w_lr_data = w_lr_payload[DATA_WIDTH-1:0];

  // Writes to r0 are dropped and do not take the port.
  assign w_wb_req = i_wb_valid && (i_wb_addr != '0);

  // Grant selection: WB first, then round-robin between full buffers.
  always_comb begin
    w_gnt = GNT_NONE;
    if (w_wb_req) begin
      w_gnt = GNT_WB;
    end else if (w_mdu_full && w_lr_full) begin
      w_gnt = r_rr_ptr ? GNT_LR : GNT_MDU;
    end else if (w_mdu_full) begin
      w_gnt = GNT_MDU;
    end else if (w_lr_full) begin
      w_gnt = GNT_LR;
    end
  end

  assign w_gnt_mdu = (w_gnt == GNT_MDU);
  assign w_gnt_lr  = (w_gnt == GNT_LR);

  // Registered write port, round-robin pointer, stall and protocol flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr_ptr          <= 1'b0;
      r_wb_stall        <= 1'b0;
      r_proto_err       <= 1'b0;
      r_rf_wen          <= 1'b0;
      r_rf_double_en    <= 1'b0;
      r_rf_waddr        <= '0;
      r_rf_wdata        <= '0;
      r_rf_double_wdata <= '0;
    end else begin
      r_rf_wen       <= 1'b0;
      r_rf_double_en <= 1'b0;
      r_wb_stall     <= (w_mdu_starved && !w_gnt_mdu) || (w_lr_starved && !w_gnt_lr);
      if (i_wb_valid && r_wb_stall) begin
        r_proto_err <= 1'b1;
      end
      unique case (w_gnt)
        GNT_WB: begin
          r_rf_wen   <= 1'b1;
          r_rf_waddr <= i_wb_addr;
          r_rf_wdata <= i_wb_data;
        end
        GNT_MDU: begin
          r_rf_double_en    <= 1'b1;
          r_rf_double_wdata <= w_mdu_data;
          r_rr_ptr          <= 1'b1;
        end
        GNT_LR: begin
          // A buffered load to r0 drains without writing.
          if (w_lr_addr != '0) begin
            r_rf_wen   <= 1'b1;
            r_rf_waddr <= w_lr_addr;
            r_rf_wdata <= w_lr_data;
          end
          r_rr_ptr <= 1'b0;
        end
        GNT_NONE: begin
        end
      endcase
    end
  end

  assign o_wb_stall        = r_wb_stall;
  assign o_proto_err       = r_proto_err;
  assign o_hilo_pending    = w_mdu_full;
  assign o_lr_pending      = w_lr_full;
  assign o_lr_pend_addr    = w_lr_addr;
  assign o_rf_wen          = r_rf_wen;
  assign o_rf_double_en    = r_rf_double_en;
  assign o_rf_waddr        = r_rf_waddr;
  assign o_rf_wdata        = r_rf_wdata;
  assign o_rf_double_wdata = r_rf_double_wdata;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_wb_valid;
  logic [5:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_stall;
  logic        i_mdu_valid;
  logic        o_mdu_ready;
  logic [63:0] i_mdu_hilo;
  logic        i_lr_valid;
  logic        o_lr_ready;
  logic [5:0]  i_lr_addr;
  logic [31:0] i_lr_data;
  logic        o_hilo_pending;
  logic        o_lr_pending;
  logic [5:0]  o_lr_pend_addr;
  logic        o_rf_wen;
  logic        o_rf_double_en;
  logic [5:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic [63:0] o_rf_double_wdata;
  logic        o_proto_err;

  int n_checks = 0;
  int n_err    = 0;

  rf_wb_arbiter dut (
    .clk               (clk),
    .rstn              (rstn),
    .i_wb_valid        (i_wb_valid),
    .i_wb_addr         (i_wb_addr),
    .i_wb_data         (i_wb_data),
    .o_wb_stall        (o_wb_stall),
    .i_mdu_valid       (i_mdu_valid),
    .o_mdu_ready       (o_mdu_ready),
    .i_mdu_hilo        (i_mdu_hilo),
    .i_lr_valid        (i_lr_valid),
    .o_lr_ready        (o_lr_ready),
    .i_lr_addr         (i_lr_addr),
    .i_lr_data         (i_lr_data),
    .o_hilo_pending    (o_hilo_pending),
    .o_lr_pending      (o_lr_pending),
    .o_lr_pend_addr    (o_lr_pend_addr),
    .o_rf_wen          (o_rf_wen),
    .o_rf_double_en    (o_rf_double_en),
    .o_rf_waddr        (o_rf_waddr),
    .o_rf_wdata        (o_rf_wdata),
    .o_rf_double_wdata (o_rf_double_wdata),
    .o_proto_err       (o_proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn        = 1'b0;
    i_wb_valid  = 1'b0;
    i_wb_addr   = '0;
    i_wb_data   = '0;
    i_mdu_valid = 1'b0;
    i_mdu_hilo  = '0;
    i_lr_valid  = 1'b0;
    i_lr_addr   = '0;
    i_lr_data   = '0;
    tick();
    tick();

    // Reset state
    check("rst_wen", o_rf_wen, 0);
    check("rst_den", o_rf_double_en, 0);
    check("rst_waddr", o_rf_waddr, 0);
    check("rst_wdata", o_rf_wdata, 0);
    check("rst_dwdata", o_rf_double_wdata, 0);
    check("rst_stall", o_wb_stall, 0);
    check("rst_proto", o_proto_err, 0);
    check("rst_mdu_rdy", o_mdu_ready, 1);
    check("rst_lr_rdy", o_lr_ready, 1);
    check("rst_hilo_pend", o_hilo_pending, 0);
    rstn = 1'b1;
    tick();

    // WB only: one-cycle pulse, then hold data; r0 write dropped
    i_wb_valid = 1'b1; i_wb_addr = 6'd5; i_wb_data = 32'hDEADBEEF;
    tick();
    check("wb_wen", o_rf_wen, 1);
    check("wb_waddr", o_rf_waddr, 5);
    check("wb_wdata", o_rf_wdata, 32'hDEADBEEF);
    check("wb_den", o_rf_double_en, 0);
    i_wb_valid = 1'b0;
    tick();
    check("wb_pulse_end", o_rf_wen, 0);
    check("wb_hold_data", o_rf_wdata, 32'hDEADBEEF);
    i_wb_valid = 1'b1; i_wb_addr = 6'd0; i_wb_data = 32'h123;
    tick();
    check("wb_r0_wen", o_rf_wen, 0);
    check("wb_r0_wdata", o_rf_wdata, 32'hDEADBEEF);
    i_wb_valid = 1'b0;

    // MDU only: accept, grant, pulse, ready returns one cycle after drain
    i_mdu_valid = 1'b1; i_mdu_hilo = 64'h11111111_22222222;
    tick();
    i_mdu_valid = 1'b0;
    check("mdu_rdy_lo", o_mdu_ready, 0);
    check("mdu_pend", o_hilo_pending, 1);
    check("mdu_den_early", o_rf_double_en, 0);
    tick();
    check("mdu_den", o_rf_double_en, 1);
    check("mdu_dwdata", o_rf_double_wdata, 64'h11111111_22222222);
    check("mdu_wen", o_rf_wen, 0);
    check("mdu_rdy_drain", o_mdu_ready, 0);
    check("mdu_pend_clr", o_hilo_pending, 0);
    tick();
    check("mdu_den_end", o_rf_double_en, 0);
    check("mdu_rdy_back", o_mdu_ready, 1);

    // rr_ptr now prefers LR: both full -> LR first, then MDU
    i_mdu_valid = 1'b1; i_mdu_hilo = 64'h33333333_44444444;
    i_lr_valid = 1'b1; i_lr_addr = 6'd7; i_lr_data = 32'h77;
    tick();
    i_mdu_valid = 1'b0; i_lr_valid = 1'b0;
    check("rr1_lr_pend_addr", o_lr_pend_addr, 7);
    tick();
    check("rr1_lr_wen", o_rf_wen, 1);
    check("rr1_lr_waddr", o_rf_waddr, 7);
    check("rr1_lr_wdata", o_rf_wdata, 32'h77);
    check("rr1_lr_den", o_rf_double_en, 0);
    tick();
    check("rr1_mdu_den", o_rf_double_en, 1);
    check("rr1_mdu_data", o_rf_double_wdata, 64'h33333333_44444444);
    check("rr1_mdu_wen", o_rf_wen, 0);
    tick();

    // Reset mid-operation with both buffers full
    i_mdu_valid = 1'b1; i_mdu_hilo = 64'hBADBADBA_DBADBAD0;
    i_lr_valid = 1'b1; i_lr_addr = 6'd10; i_lr_data = 32'hBAD;
    tick();
    i_mdu_valid = 1'b0; i_lr_valid = 1'b0;
    check("mid_both_mdu", o_hilo_pending, 1);
    check("mid_both_lr", o_lr_pending, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mid_rst_wen", o_rf_wen, 0);
    check("mid_rst_den", o_rf_double_en, 0);
    check("mid_rst_mdu_rdy", o_mdu_ready, 1);
    check("mid_rst_lr_rdy", o_lr_ready, 1);
    check("mid_rst_hilo", o_hilo_pending, 0);
    check("mid_rst_lrpend", o_lr_pending, 0);
    tick();
    check("mid_after_wen", o_rf_wen, 0);
    check("mid_after_den", o_rf_double_en, 0);
    tick();
    check("mid_after2_wen", o_rf_wen, 0);
    check("mid_after2_den", o_rf_double_en, 0);

    // Round-robin from reset: MDU first, then LR
    i_mdu_valid = 1'b1; i_mdu_hilo = 64'h5A5A5A5A_A5A5A5A5;
    i_lr_valid = 1'b1; i_lr_addr = 6'd9; i_lr_data = 32'h55;
    tick();
    i_mdu_valid = 1'b0; i_lr_valid = 1'b0;
    tick();
    check("rr0_mdu_den", o_rf_double_en, 1);
    check("rr0_mdu_data", o_rf_double_wdata, 64'h5A5A5A5A_A5A5A5A5);
    check("rr0_mdu_wen", o_rf_wen, 0);
    tick();
    check("rr0_lr_wen", o_rf_wen, 1);
    check("rr0_lr_waddr", o_rf_waddr, 9);
    check("rr0_lr_wdata", o_rf_wdata, 32'h55);
    check("rr0_lr_den", o_rf_double_en, 0);
    tick();

    // Starvation: LR held off by WB until the counter saturates
    i_wb_valid = 1'b1; i_wb_addr = 6'd1; i_wb_data = 32'h100;
    i_lr_valid = 1'b1; i_lr_addr = 6'd3; i_lr_data = 32'hCAFE;
    tick();
    i_lr_valid = 1'b0;
    check("stv_lr_pend", o_lr_pending, 1);
    check("stv_wb_wen", o_rf_wen, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("stv_nostall_%0d", i), o_wb_stall, 0);
      check($sformatf("stv_wb_waddr_%0d", i), o_rf_waddr, 1);
    end
    tick();
    check("stv_stall", o_wb_stall, 1);
    i_wb_valid = 1'b0;
    tick();
    check("stv_lr_wen", o_rf_wen, 1);
    check("stv_lr_waddr", o_rf_waddr, 3);
    check("stv_lr_wdata", o_rf_wdata, 32'hCAFE);
    check("stv_stall_clr", o_wb_stall, 0);
    check("stv_no_proto", o_proto_err, 0);
    tick();

    // Violation: WB during stall still wins, proto_err is sticky
    i_wb_valid = 1'b1; i_wb_addr = 6'd2; i_wb_data = 32'h200;
    i_lr_valid = 1'b1; i_lr_addr = 6'd4; i_lr_data = 32'hF00D;
    tick();
    i_lr_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
    end
    tick();
    check("vio_stall", o_wb_stall, 1);
    check("vio_proto_pre", o_proto_err, 0);
    i_wb_data = 32'h201;
    tick();
    i_wb_valid = 1'b0;
    check("vio_wb_wen", o_rf_wen, 1);
    check("vio_wb_waddr", o_rf_waddr, 2);
    check("vio_wb_wdata", o_rf_wdata, 32'h201);
    check("vio_proto", o_proto_err, 1);
    check("vio_stall_held", o_wb_stall, 1);
    tick();
    check("vio_lr_wen", o_rf_wen, 1);
    check("vio_lr_waddr", o_rf_waddr, 4);
    check("vio_stall_clr", o_wb_stall, 0);
    tick();
    check("vio_proto_sticky", o_proto_err, 1);

    // Buffered load to r0 drains without a write
    i_lr_valid = 1'b1; i_lr_addr = 6'd0; i_lr_data = 32'hEE;
    tick();
    i_lr_valid = 1'b0;
    check("lr0_pend", o_lr_pending, 1);
    tick();
    check("lr0_wen", o_rf_wen, 0);
    check("lr0_drained", o_lr_pending, 0);
    check("lr0_wdata_hold", o_rf_wdata, 32'hF00D);
    check("lr0_proto", o_proto_err, 1);

    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("proto_rst", o_proto_err, 0);
    check("waddr_rst", o_rf_waddr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
